// File: rtl/mxu_result_serializer.sv
// Two-slot result buffer behind the MXU core; streams Y element-by-element on valid/ready with row/matrix flags.
// Optional build macro MXU_SER_COLMAJOR_EN switches the emit order to column-major.
module mxu_result_serializer #(
  parameter int DIM   = 4,
  parameter int WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   in_y,
  output logic                                 in_ready,
  output logic [WIDTH-1:0]                     out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last_row,
  output logic                                 out_last,
  output logic                                 overflow,
  output logic [1:0]                           occupancy
);

  localparam int N  = DIM * DIM;
  localparam int KW = $clog2(N);
  localparam int RW = $clog2(DIM);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                               state;
  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   slot [2];
  logic                                 wp;
  logic                                 rp;
  logic [KW-1:0]                        k;

  logic                                 hs;
  logic                                 final_pop;
  logic                                 cap;
  logic                                 drop;
  logic [1:0]                           occ_n;
  logic [RW-1:0]                        row;
  logic [RW-1:0]                        col;
  logic                                 row_end;

  always_comb begin
    hs        = out_valid && out_ready;
    final_pop = hs && (k == K_LAST);
    // Capture/drop decided on pre-edge occupancy, even if the head drains this cycle.
    cap       = in_valid && (occupancy != 2'd2);
    drop      = in_valid && (occupancy == 2'd2);
    occ_n     = occupancy;
    if (cap && !final_pop)
      occ_n = occupancy + 2'd1;
    else if (!cap && final_pop)
      occ_n = occupancy - 2'd1;
`ifdef MXU_SER_COLMAJOR_EN
    row = RW'(int'(k) % DIM);
    col = RW'(int'(k) / DIM);
`else
    row = RW'(int'(k) / DIM);
    col = RW'(int'(k) % DIM);
`endif
    row_end = ((int'(k) % DIM) == DIM - 1);
  end

  // Outputs derive only from registered state; gated to zero while idle.
  assign in_ready     = (occupancy != 2'd2);
  assign out_data     = out_valid ? slot[rp][row][col] : '0;
  assign out_last_row = out_valid && row_end;
  assign out_last     = out_valid && (k == K_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      k         <= '0;
      occupancy <= 2'd0;
      overflow  <= 1'b0;
    end else begin
      if (cap) begin
        slot[wp] <= in_y;
        wp       <= ~wp;
      end
      if (drop)
        overflow <= 1'b1;
      if (hs) begin
        if (final_pop) begin
          k  <= '0;
          rp <= ~rp;
        end else begin
          k <= k + 1'b1;
        end
      end
      occupancy <= occ_n;
      case (state)
        IDLE: begin
          if (occ_n != 2'd0) begin
            state     <= STREAM;
            out_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (occ_n == 2'd0) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mxu_result_serializer.sv
// Scoreboard bench for mxu_result_serializer (DIM=2, WIDTH=8): directed scenarios then random traffic.
module tb_mxu_result_serializer;

  localparam int DIM   = 2;
  localparam int WIDTH = 8;
  localparam int N     = DIM * DIM;

  typedef logic [DIM-1:0][DIM-1:0][WIDTH-1:0] mat_t;
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             lr;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  mat_t             in_y;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last_row;
  logic             out_last;
  logic             overflow;
  logic [1:0]       occupancy;

  always #5 clk = ~clk;

  mxu_result_serializer #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_y         (in_y),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last_row (out_last_row),
    .out_last     (out_last),
    .overflow     (overflow),
    .occupancy    (occupancy)
  );

  exp_t             exp_q[$];
  int               m_occ = 0;
  bit               m_ovf = 1'b0;
  bit               m_rst = 1'b0;
  bit               pend_last = 1'b0;
  bit               started = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference order: index k walks row-major (or column-major) over the matrix.
  task automatic push_matrix(input mat_t m);
    exp_t e;
    int   r;
    int   c;
    for (int kk = 0; kk < N; kk++) begin
`ifdef MXU_SER_COLMAJOR_EN
      r = kk % DIM;
      c = kk / DIM;
`else
      r = kk / DIM;
      c = kk % DIM;
`endif
      e.data = m[r][c];
      e.lr   = ((kk % DIM) == DIM - 1);
      e.last = (kk == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // Buffer model: accepted matrices queue up, a third one while full is lost.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_occ     = 0;
      m_ovf     = 1'b0;
      pend_last = 1'b0;
      m_rst     = 1'b1;
      started   = 1'b1;
    end else if (started) begin
      m_rst = 1'b0;
      if (in_valid && m_occ < 2) begin
        push_matrix(in_y);
        m_occ++;
      end else if (in_valid) begin
        m_ovf = 1'b1;
      end
      if (pend_last) m_occ--;
      pend_last = 1'b0;
    end
  end

  // Monitor: status every cycle, element contents on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(m_occ != 0));
      chk("occupancy", 32'(occupancy), 32'(m_occ));
      chk("in_ready",  32'(in_ready),  32'(m_occ < 2));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      if (m_rst) begin
        chk("rst_out_data", 32'(out_data),     32'd0);
        chk("rst_last_row", 32'(out_last_row), 32'd0);
        chk("rst_last",     32'(out_last),     32'd0);
      end
      if (out_valid && prev_stall)
        chk("hold_data", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %0h, expected no element at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data",     32'(out_data),     32'(e.data));
          chk("out_last_row", 32'(out_last_row), 32'(e.lr));
          chk("out_last",     32'(out_last),     32'(e.last));
          if (e.last) pend_last = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready && !reset;
      prev_data  = out_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic capture(input mat_t m);
    in_valid = 1'b1;
    in_y     = m;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  function automatic mat_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    mat_t m;
    m[0][0] = a;
    m[0][1] = b;
    m[1][0] = c;
    m[1][1] = d;
    return m;
  endfunction

  initial begin
    int t;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_y      = '0;
    out_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Single matrix, free-running consumer
    out_ready = 1'b1;
    capture(mk(8'h01, 8'h02, 8'h03, 8'h04));
    tick(6);

    // Backpressure 1,0,0 pattern
    capture(mk(8'h01, 8'h02, 8'h03, 8'h04));
    for (int i = 0; i < 12; i++) begin
      out_ready = (i % 3 == 0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(4);

    // Back-to-back captures two cycles apart
    capture(mk(8'h01, 8'h02, 8'h03, 8'h04));
    tick(1);
    capture(mk(8'h05, 8'h06, 8'h07, 8'h08));
    tick(10);

    // Overflow with stalled consumer
    out_ready = 1'b0;
    capture(mk(8'h11, 8'h12, 8'h13, 8'h14));
    capture(mk(8'h21, 8'h22, 8'h23, 8'h24));
    capture(mk(8'h31, 8'h32, 8'h33, 8'h34));
    tick(3);
    out_ready = 1'b1;
    tick(12);

    // Drop racing the head matrix's final pop
    do_reset();
    out_ready = 1'b0;
    capture(mk(8'h41, 8'h42, 8'h43, 8'h44));
    capture(mk(8'h51, 8'h52, 8'h53, 8'h54));
    tick(2);
    out_ready = 1'b1;
    tick(3);
    capture(mk(8'h61, 8'h62, 8'h63, 8'h64));
    tick(8);

    // Reset after two elements, then restart from (0,0)
    do_reset();
    out_ready = 1'b1;
    capture(mk(8'h71, 8'h72, 8'h73, 8'h74));
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    capture(mk(8'h81, 8'h82, 8'h83, 8'h84));
    tick(6);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) == 0);
      in_y      = $urandom;
      out_ready = ($urandom_range(3) != 0);
      tick(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    t = 0;
    while (m_occ != 0 && t < 200) begin
      tick(1);
      t++;
    end
    if (m_occ != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: occupancy model %0d, expected 0", m_occ);
    end
    tick(2);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
